// File: rtl/cs_pkg.sv
// cs_pkg: shared constants and parameter helpers for the CS window filter.
package cs_pkg;

  localparam int CS_DATA_W = 8;
  localparam int CS_WIN    = 9;
  localparam int CS_SHIFT  = 3;

  // Running-sum width: WIN samples of DATA_W bits cannot overflow this.
  function automatic int cs_sum_w(input int data_w, input int win);
    return data_w + $clog2(win);
  endfunction

  // Output width: (sum + WIN*Xappr) needs one more doubling, minus the shift.
  function automatic int cs_out_w(input int data_w, input int win, input int shift);
    return data_w + $clog2(2 * win) - shift;
  endfunction

  // Legal window depth is 2..64.
  // The shift must leave at least one result bit.
  function automatic bit cs_params_ok(input int data_w, input int win, input int shift);
    return (win >= 2) && (win <= 64) && (shift >= 0) &&
           (shift < data_w + $clog2(2 * win));
  endfunction

endpackage

// File: rtl/cs_appr_sel.sv
// cs_appr_sel: picks Xappr, the largest window sample not above the window
// average. There is no divider: s qualifies iff s*WIN <= sum. Non-qualifying
// lanes become 0 before a max-reduction tree. This is safe because the window
// minimum always qualifies, so a real qualifier is never beaten by a 0.
module cs_appr_sel import cs_pkg::*; #(
  parameter int DATA_W = CS_DATA_W,
  parameter int WIN    = CS_WIN,
  parameter int SUM_W  = cs_sum_w(CS_DATA_W, CS_WIN)
) (
  input  logic [WIN-1:0][DATA_W-1:0] win,
  input  logic [SUM_W-1:0]           sum,
  output logic [DATA_W-1:0]          xappr
);

  localparam int CMP_W = DATA_W + $clog2(2 * WIN);
  localparam int LVLS  = $clog2(WIN);
  localparam int NP    = 1 << LVLS;

  logic [WIN-1:0] qual;

  // Per-lane qualify test, evaluated at full width.
  for (genvar i = 0; i < WIN; i++) begin : g_qual
    assign qual[i] = (CMP_W'(win[i]) * CMP_W'(WIN)) <= CMP_W'(sum);
  end

  // Max tree. Level 0 holds the masked leaves, padded with zeros up to a power of two.
  for (genvar l = 0; l <= LVLS; l++) begin : lvl
    logic [(NP>>l)-1:0][DATA_W-1:0] v;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g
        if (i < WIN) begin : g_live
          assign v[i] = qual[i] ? win[i] : '0;
        end else begin : g_pad
          assign v[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < (NP >> l); j++) begin : g
        assign v[j] = (lvl[l-1].v[2*j] > lvl[l-1].v[2*j+1]) ?
                      lvl[l-1].v[2*j] : lvl[l-1].v[2*j+1];
      end
    end
  end

  assign xappr = lvl[LVLS].v[0];

endmodule

// File: rtl/cs_win_filter.sv
// cs_win_filter: sliding-window CS filter.
// Stage 1 shifts accepted samples into the window and keeps a running sum.
// Stage 2 computes y = (sum + WIN*Xappr) >> SHIFT one edge later.
// Define CS_WIN_CLR_EN to add a synchronous clr input that empties the window.
module cs_win_filter import cs_pkg::*; #(
  parameter int DATA_W = CS_DATA_W,
  parameter int WIN    = CS_WIN,
  parameter int SHIFT  = CS_SHIFT,
  localparam int OUT_W  = cs_out_w(DATA_W, WIN, SHIFT),
  localparam int FILL_W = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CS_WIN_CLR_EN
  input  logic              clr,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  output logic [OUT_W-1:0]  y,
  output logic [FILL_W-1:0] fill
);

  localparam int SUM_W = cs_sum_w(DATA_W, WIN);
  localparam int EXT_W = DATA_W + $clog2(2 * WIN);

  if (!cs_params_ok(DATA_W, WIN, SHIFT)) begin : g_bad_params
    $error("cs_win_filter: illegal DATA_W/WIN/SHIFT combination");
  end

  logic                      clr_w;
  logic [WIN-1:0][DATA_W-1:0] win_q, win_d, base_win;
  logic [SUM_W-1:0]          sum_q, sum_d, base_sum;
  logic [FILL_W-1:0]         fill_q, fill_d, base_fill;
  logic [DATA_W-1:0]         oldest, xappr;
  logic [EXT_W-1:0]          ext;
  logic [OUT_W-1:0]          y_calc;
  // vld_pipe[0]: this accept fills the window; [1]: stage-1 reg; [2]: out_valid
  logic [2:0]                vld_pipe;

`ifdef CS_WIN_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  // Next window/sum/fill: apply clr first, then any accepted sample on top.
  always_comb begin
    base_win  = clr_w ? '0 : win_q;
    base_sum  = clr_w ? '0 : sum_q;
    base_fill = clr_w ? '0 : fill_q;
    oldest    = (base_fill == FILL_W'(WIN)) ? base_win[WIN-1] : '0;
    win_d     = base_win;
    sum_d     = base_sum;
    fill_d    = base_fill;
    if (in_valid) begin
      win_d  = {base_win[WIN-2:0], x};
      sum_d  = base_sum + SUM_W'(x) - SUM_W'(oldest);
      fill_d = (base_fill == FILL_W'(WIN)) ? base_fill : base_fill + 1'b1;
    end
  end

  assign vld_pipe[0] = in_valid && (fill_d == FILL_W'(WIN));

  cs_appr_sel #(.DATA_W(DATA_W), .WIN(WIN), .SUM_W(SUM_W)) u_appr_sel (
    .win   (win_q),
    .sum   (sum_q),
    .xappr (xappr)
  );

  assign ext    = EXT_W'(sum_q) + EXT_W'(WIN) * EXT_W'(xappr);
  assign y_calc = OUT_W'(ext >> SHIFT);

  // Stage 1: window shift register, running sum, fill counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  // Valid pipeline and output register. clr kills a result still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe[2:1] <= '0;
      y             <= '0;
    end else begin
      vld_pipe[2:1] <= {vld_pipe[1] & ~clr_w, vld_pipe[0]};
      if (vld_pipe[1] && !clr_w) y <= y_calc;
    end
  end

  assign out_valid = vld_pipe[2];
  assign fill      = fill_q;

endmodule

// File: tb/tb_cs_win_filter.sv
// Directed bench for cs_win_filter at default parameters.
module tb_cs_win_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] x = '0;
`ifdef CS_WIN_CLR_EN
  logic       clr = 1'b0;
`endif
  logic       out_valid;
  logic [9:0] y;
  logic [3:0] fill;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cs_win_filter dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CS_WIN_CLR_EN
    .clr       (clr),
`endif
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y         (y),
    .fill      (fill)
  );

  typedef struct {
    string name;
    int    s[9];
    int    exp_y;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs at a negedge; return at the next negedge, after the edge has acted.
  task automatic send(input bit v, input int xv);
    in_valid = v;
    x = 8'(xv);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"ramp1_9",  '{1,2,3,4,5,6,7,8,9},             11};
    vecs[1] = '{"zeros_90", '{0,0,0,0,0,0,0,0,90},            11};
    vecs[2] = '{"all_255",  '{255,255,255,255,255,255,255,255,255}, 573};
    vecs[3] = '{"pi_mix",   '{3,1,4,1,5,9,2,6,5},             9};
    vecs[4] = '{"all_7",    '{7,7,7,7,7,7,7,7,7},             15};
    vecs[5] = '{"100_zeros",'{100,0,0,0,0,0,0,0,0},           12};
    vecs[6] = '{"tens",     '{10,20,30,40,50,60,70,80,90},    112};

    // Reset state, while reset is held low.
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_fill", int'(fill), 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven windows
    foreach (vecs[k]) begin
      do_reset();
      for (int i = 0; i < 9; i++) begin
        send(1'b1, vecs[k].s[i]);
        chk({vecs[k].name, "_fill"}, int'(fill), i + 1);
        chk({vecs[k].name, "_early_vld"}, int'(out_valid), 0);
      end
      send(1'b0, 0);
      chk({vecs[k].name, "_vld"}, int'(out_valid), 1);
      chk({vecs[k].name, "_y"}, int'(y), vecs[k].exp_y);
      send(1'b0, 0);
      chk({vecs[k].name, "_pulse"}, int'(out_valid), 0);
      chk({vecs[k].name, "_yhold"}, int'(y), vecs[k].exp_y);
    end

    // Back-to-back 1..10: results for windows 1..9 and 2..10 on consecutive cycles
    do_reset();
    for (int i = 1; i <= 10; i++) send(1'b1, i);
    chk("b2b_vld9", int'(out_valid), 1);
    chk("b2b_y9", int'(y), 11);
    chk("b2b_fill_sat", int'(fill), 9);
    send(1'b0, 0);
    chk("b2b_vld10", int'(out_valid), 1);
    chk("b2b_y10", int'(y), 13);
    send(1'b0, 0);
    chk("b2b_done", int'(out_valid), 0);

    // Gap of 5 idle cycles after sample 4
    do_reset();
    for (int i = 1; i <= 4; i++) send(1'b1, i);
    for (int g = 0; g < 5; g++) begin
      send(1'b0, 99);
      chk("gap_fill", int'(fill), 4);
      chk("gap_vld", int'(out_valid), 0);
    end
    for (int i = 5; i <= 9; i++) send(1'b1, i);
    send(1'b0, 0);
    chk("gap_vld_end", int'(out_valid), 1);
    chk("gap_y", int'(y), 11);

    // Async reset between edges while a result is showing
    do_reset();
    for (int i = 1; i <= 9; i++) send(1'b1, i);
    send(1'b0, 0);
    chk("arst_pre_vld", int'(out_valid), 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_vld", int'(out_valid), 0);
    chk("arst_y", int'(y), 0);
    chk("arst_fill", int'(fill), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    send(1'b0, 0);
    chk("arst_no_pending", int'(out_valid), 0);
    chk("arst_fill_after", int'(fill), 0);

`ifdef CS_WIN_CLR_EN
    // clr together with a sample: window restarts holding only that sample
    do_reset();
    for (int i = 1; i <= 9; i++) send(1'b1, i);
    clr = 1'b1;
    send(1'b1, 7);
    clr = 1'b0;
    chk("clr_fill", int'(fill), 1);
    chk("clr_suppress", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 7);
      chk("clr_refill_vld", int'(out_valid), 0);
    end
    chk("clr_refill_fill", int'(fill), 9);
    send(1'b0, 0);
    chk("clr_vld", int'(out_valid), 1);
    chk("clr_y", int'(y), 15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cs_win_filter.md
Name: cs_win_filter

Overview:
- Parametrised successor to the fixed 9-tap, 8-bit CS filter.
- Holds a sliding window of the last WIN samples and computes the window average Xavg.
- Selects Xappr, the largest window sample not exceeding Xavg.
- Emits Y = floor((sum + WIN*Xappr) / 2^SHIFT).
- Adds in_valid/out_valid framing, a fill counter, and a generalised width, depth and scale.
- Sits between the sample source and downstream consumer in the CS datapath.

Parameters:
- DATA_W, 8: sample width in bits.
- WIN, 9: window depth in samples; legal range 2..64.
- SHIFT, 3: output right-shift (divide by 2^SHIFT).
- OUT_W, derived localparam = DATA_W + $clog2(2*WIN) - SHIFT: output width, 10 at defaults.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset (clears on reset==0 immediately).
- in_valid, in, 1: x is a new sample this cycle.
- x, in, DATA_W: input sample, unsigned.
- out_valid, out, 1: y is valid this cycle; one-cycle pulse per result.
- y, out, OUT_W: filtered result, unsigned.
- fill, out, $clog2(WIN+1): number of samples currently in the window; saturates at WIN.

Behaviour:
- Reset values (while reset==0): window registers 0, sum 0, fill 0, out_valid 0, y 0. No output is pending after release.
- Stage 1, edge where in_valid==1:
  - Shift x into the window; the oldest entry drops out.
  - sum_next = sum + x - oldest. The oldest entry reads 0 while fill<WIN.
  - sum width is DATA_W + $clog2(WIN); no overflow is possible.
  - fill increments and saturates at WIN.
  - in_valid==0: window, sum and fill hold.
- Stage 2, registered one edge after stage 1:
  - Fires only if the stage-1 accept left fill==WIN. Then out_valid=1 and y is loaded.
  - Otherwise out_valid=0 and y holds its last value.
- Latency: sample accepted at edge k gives y/out_valid at edge k+1. Back-to-back in_valid gives one result per cycle.
- Xavg test uses no divider: sample s qualifies iff s*WIN <= sum, evaluated at full width.
- Xappr is the maximum qualifying sample. One always exists, because min <= average.
- Ties and duplicates are fine; Xappr is a value, not an index.
- y = (sum + WIN*Xappr) >> SHIFT, computed at DATA_W + $clog2(2*WIN) bits, then truncated to OUT_W. The truncation drops only zero bits.
- The first result appears on the WIN-th accepted sample. Samples 1..WIN-1 produce no out_valid.
- Gaps in in_valid: no result, and the window does not age.
- Reset mid-operation discards the window and any in-flight stage-2 result; fill restarts from 0.

Optional Feature:
- Macro CS_WIN_CLR_EN.
- Defined:
  - Adds input port clr (1 bit, synchronous, active-high).
  - clr=1 empties the window: fill=0, sum=0, and the pending stage-2 result is suppressed (out_valid=0 next edge).
  - clr and in_valid in the same cycle: the window is cleared, then x is loaded as its sole entry (fill=1, sum=x).
- Undefined: no clr port; the window empties only on reset.

Decomposition:
- Package cs_pkg holds:
  - default DATA_W/WIN/SHIFT constants;
  - the OUT_W and SUM_W derivation functions;
  - a parameter-legality check function (WIN range; SHIFT < DATA_W+$clog2(2*WIN)).
- Sub-module cs_appr_sel: combinational; takes the window vector, sum and WIN, and returns Xappr.
  - Implemented as a qualify-mask followed by a max-reduction tree.
- Top level holds the window shift register, running sum, fill counter and output register.

Test Plan:
- Async reset mid-stream: assert reset low between edges -> out_valid, y and fill drop to 0 immediately, without a clock edge.
- Defaults, samples 1..9 back-to-back -> no out_valid for the first 8 samples; after the 9th, out_valid=1 with y=0x00B (sum 45, Xappr 5).
- Continue with sample 10 -> y=0x00D (window 2..10, sum 54, Xappr 6).
- Window of eight 0s then 90 -> Xavg 10, Xappr 0, y=0x00B.
- Nine samples of 255 -> y=0x23D (max value; no truncation loss).
- in_valid gap of 5 cycles between samples 4 and 5 -> fill holds at 4 and there is no out_valid. Final result equals the gap-free result.
- CS_WIN_CLR_EN defined: full window, then clr together with in_valid, x=7 -> fill=1 and no out_valid. 8 more samples of 7 -> y=(63+63)>>3=0x00F.
